// File: rtl/tropang_pkg.sv
// tropang_pkg: download region bounds and sequencer FSM states
package tropang_pkg;
  localparam logic [16:0] DEF_SP_BASE  = 17'h10000;
  localparam logic [16:0] DEF_SP_END   = 17'h1BFFF;
  localparam logic [16:0] DEF_CPU_END  = 17'h09FFF;
  localparam logic [16:0] DEF_BRAM_END = 17'h1C31F;
  localparam int DEF_ACK_TIMEOUT = 255;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
endpackage

// File: rtl/toggle_port.sv
// toggle_port: toggle req/ack handshake with saturating ack timeout
module toggle_port #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk_mem,
  input  logic reset,
  input  logic ack,
  input  logic issue,
  input  logic active,
  output logic req,
  output logic match,
  output logic timeout
);
  logic [7:0] cnt;
  assign match = req == ack;
  assign timeout = active && !match && cnt == 8'(ACK_TIMEOUT);
  always_ff @(posedge clk_mem) begin
    if (reset) begin
      req <= ack;
      cnt <= '0;
    end else begin
      if (issue) req <= ~req;
      else if (timeout) req <= ack;
      if (issue) cnt <= '0;
      else if (active && !match && cnt != 8'hFF) cnt <= cnt + 8'd1;
    end
  end
endmodule

// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer: routes HPS ROM download bytes to SDRAM ports or BRAM loader
import tropang_pkg::*;
module rom_dl_sequencer #(
  parameter logic [16:0] SP_BASE  = DEF_SP_BASE,
  parameter logic [16:0] SP_END   = DEF_SP_END,
  parameter logic [16:0] CPU_END  = DEF_CPU_END,
  parameter logic [16:0] BRAM_END = DEF_BRAM_END,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic        clk_mem,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        dl_wr,
  output logic [16:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        rom_loaded,
  output logic        dl_error
);
  state_t state_q, state_d;
  logic wr_q, dn_q, pend_q, sel2, iss1, iss2, match1, match2, tmo1, tmo2;
  logic [16:0] a;
  logic [23:0] off;
  logic ev, lo_ok, hit1, hit2, hitb, dn_fall;
  assign a = ioctl_addr[16:0];
  assign lo_ok = ioctl_addr[24:17] == 8'd0;
  assign ev = ioctl_download && ioctl_wr && !wr_q && ioctl_index == 8'd0 && state_q == IDLE;
  assign hit1 = lo_ok && a <= CPU_END;
  assign hit2 = lo_ok && a >= SP_BASE && a <= SP_END;
  assign hitb = lo_ok && ((a > CPU_END && a < SP_BASE) || (a > SP_END && a <= BRAM_END));
  assign off = {7'd0, a} - {7'd0, SP_BASE};
  assign ioctl_wait = state_q != IDLE;
  assign dn_fall = !ioctl_download && dn_q;
  toggle_port #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_p1 (
    .clk_mem(clk_mem), .reset(reset), .ack(port1_ack), .issue(iss1),
    .active(state_q == WAIT && !sel2), .req(port1_req), .match(match1), .timeout(tmo1)
  );
  toggle_port #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_p2 (
    .clk_mem(clk_mem), .reset(reset), .ack(port2_ack), .issue(iss2),
    .active(state_q == WAIT && sel2), .req(port2_req), .match(match2), .timeout(tmo2)
  );
  always_comb begin
    state_d = state_q;
    iss1 = 1'b0;
    iss2 = 1'b0;
    case (state_q)
      IDLE: state_d = ev && (hit1 || hit2) ? ISSUE : IDLE;
      ISSUE: begin
        iss1 = !sel2;
        iss2 = sel2;
        state_d = WAIT;
      end
      WAIT: state_d = (sel2 ? (match2 || tmo2) : (match1 || tmo1)) ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_mem) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q <= 1'b0;
      dn_q <= 1'b0;
      pend_q <= 1'b0;
      sel2 <= 1'b0;
      dl_wr <= 1'b0;
      dl_addr <= '0;
      dl_data <= '0;
      port1_a <= '0;
      port1_ds <= '0;
      port1_d <= '0;
      port2_a <= '0;
      port2_ds <= '0;
      port2_d <= '0;
      rom_loaded <= 1'b0;
      dl_error <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= ioctl_wr;
      dn_q <= ioctl_download;
      dl_wr <= ev && hitb;
      if (ev && hitb) begin
        dl_addr <= a;
        dl_data <= ioctl_dout;
      end
      if (ev && hit1) begin
        sel2 <= 1'b0;
        port1_a <= ioctl_addr[23:1];
        port1_ds <= {ioctl_addr[0], ~ioctl_addr[0]};
        port1_d <= {ioctl_dout, ioctl_dout};
      end
      if (ev && hit2) begin
        sel2 <= 1'b1;
        port2_a <= {off[23:16], off[13:0], off[15]};
        port2_ds <= {off[14], ~off[14]};
        port2_d <= {ioctl_dout, ioctl_dout};
      end
      if (ioctl_download && !dn_q) begin
        rom_loaded <= 1'b0;
        dl_error <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        if (tmo1 || tmo2) dl_error <= 1'b1;
        // a falling edge seen mid-write is held until the write retires
        if ((pend_q || dn_fall) && state_q == IDLE) begin
          rom_loaded <= !dl_error;
          pend_q <= 1'b0;
        end else if (dn_fall) pend_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rom_dl_sequencer.sv
// tb_rom_dl_sequencer: randomized download against a byte-level region model
module tb_rom_dl_sequencer;
  logic clk_mem = 0, reset = 1, ioctl_download = 0, ioctl_wr = 0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_dout = '0, ioctl_index = '0;
  logic port1_ack = 1, port2_ack = 0;
  logic ioctl_wait, port1_req, port2_req, dl_wr, rom_loaded, dl_error;
  logic [22:0] port1_a, port2_a;
  logic [1:0] port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;
  logic [16:0] dl_addr;
  logic [7:0] dl_data;
  int checks = 0, errors = 0;
  int lat_min = 0, lat_max = 0, c1 = 0, l1 = 0, c2 = 0, l2 = 0, n1 = 0, n2 = 0, nb = 0;
  bit hold1 = 0, hold2 = 0;
  logic p1_prev, p2_prev;
  logic [7:0] m1[int], m2[int], mb[int];

  rom_dl_sequencer dut (
    .clk_mem(clk_mem), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .ioctl_wait(ioctl_wait), .port1_req(port1_req), .port1_ack(port1_ack),
    .port1_a(port1_a), .port1_ds(port1_ds), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d), .dl_wr(dl_wr), .dl_addr(dl_addr),
    .dl_data(dl_data), .rom_loaded(rom_loaded), .dl_error(dl_error)
  );

  always #5 clk_mem = ~clk_mem;

  // SDRAM side: record each new request into byte memories, then ack after a random latency
  always @(negedge clk_mem) begin
    if (!reset && port1_req !== p1_prev && port1_req !== port1_ack) begin
      n1++;
      m1[int'(port1_a) * 2 + int'(port1_ds[1])] = port1_ds[1] ? port1_d[15:8] : port1_d[7:0];
      c1 = 0;
      l1 = $urandom_range(lat_max, lat_min);
    end
    if (!reset && port2_req !== p2_prev && port2_req !== port2_ack) begin
      n2++;
      m2[int'(port2_a) * 2 + int'(port2_ds[1])] = port2_ds[1] ? port2_d[15:8] : port2_d[7:0];
      c2 = 0;
      l2 = $urandom_range(lat_max, lat_min);
    end
    p1_prev = port1_req;
    p2_prev = port2_req;
    if (dl_wr === 1'b1) begin
      nb++;
      mb[int'(dl_addr)] = dl_data;
    end
    if (!reset && !hold1 && port1_req !== port1_ack) begin
      if (c1 >= l1) port1_ack = port1_req;
      else c1++;
    end
    if (!reset && !hold2 && port2_req !== port2_ack) begin
      if (c2 >= l2) port2_ack = port2_req;
      else c2++;
    end
  end

  task automatic hps_write(input logic [24:0] addr, input logic [7:0] data,
                           input logic [7:0] idx, output int wcnt);
    @(negedge clk_mem);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_index = idx;
    ioctl_wr = 1;
    @(negedge clk_mem);
    ioctl_wr = 0;
    wcnt = 0;
    while (ioctl_wait === 1'b1 && wcnt < 2000) begin
      wcnt++;
      @(negedge clk_mem);
    end
    if (wcnt >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_bound: ioctl_wait=%b after %0d cycles, required 0", ioctl_wait, wcnt);
    end
  endtask

  task automatic test_reset;
    reset = 1;
    port1_ack = 1;
    port2_ack = 0;
    repeat (3) @(negedge clk_mem);
    checks++;
    if ({port1_req, port2_req} !== 2'b10) begin
      errors++;
      $display("FAIL reset_req: req1/req2=%b, required 10", {port1_req, port2_req});
    end
    checks++;
    if ({ioctl_wait, dl_wr, rom_loaded, dl_error} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: wait/dl_wr/loaded/error=%b, required 0000",
               {ioctl_wait, dl_wr, rom_loaded, dl_error});
    end
    checks++;
    if ({port1_a, port1_ds, port1_d, port2_a, port2_ds, port2_d, dl_addr, dl_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: p1a=%h p2a=%h dla=%h dld=%h, required all 0",
               port1_a, port2_a, dl_addr, dl_data);
    end
    reset = 0;
    repeat (4) @(negedge clk_mem);
    checks++;
    if (n1 != 0 || n2 != 0 || port1_req !== port1_ack || port2_req !== port2_ack) begin
      errors++;
      $display("FAIL reset_no_phantom: requests %0d/%0d issued, required 0/0", n1, n2);
    end
  endtask

  task automatic test_p1_write;
    int w;
    logic r;
    ioctl_download = 1;
    repeat (2) @(negedge clk_mem);
    lat_min = 4;
    lat_max = 4;
    r = port1_req;
    hps_write(25'h00003, 8'hA5, 8'h00, w);
    checks++;
    if (w != 6) begin
      errors++;
      $display("FAIL p1_wait_len: ioctl_wait high %0d cycles, required 6", w);
    end
    checks++;
    if (port1_a !== 23'h1 || port1_ds !== 2'b10 || port1_d !== 16'hA5A5) begin
      errors++;
      $display("FAIL p1_map: a=%h ds=%b d=%h, required 000001 10 a5a5", port1_a, port1_ds, port1_d);
    end
    checks++;
    if (port1_req === r || port1_req !== port1_ack || n1 != 1 || n2 != 0) begin
      errors++;
      $display("FAIL p1_handshake: req=%b ack=%b n1=%0d n2=%0d, required toggled/matched 1 0",
               port1_req, port1_ack, n1, n2);
    end
  endtask

  task automatic test_p2_write;
    int w;
    lat_min = 0;
    lat_max = 3;
    hps_write(25'h14005, 8'h5A, 8'h00, w);
    checks++;
    if (w != l2 + 2) begin
      errors++;
      $display("FAIL p2_wait_len: ioctl_wait high %0d cycles, required %0d", w, l2 + 2);
    end
    checks++;
    if (port2_a !== 23'h00000A || port2_ds !== 2'b10 || port2_d !== 16'h5A5A) begin
      errors++;
      $display("FAIL p2_map: a=%h ds=%b d=%h, required 00000a 10 5a5a", port2_a, port2_ds, port2_d);
    end
    checks++;
    if (port1_a !== 23'h1 || port1_ds !== 2'b10 || port1_d !== 16'hA5A5 || n1 != 1 || n2 != 1) begin
      errors++;
      $display("FAIL p2_p1_untouched: p1a=%h n1=%0d n2=%0d, required 000001 1 1", port1_a, n1, n2);
    end
  endtask

  task automatic test_bram_and_drop;
    int w;
    hps_write(25'h1C100, 8'h3C, 8'h00, w);
    checks++;
    if (w != 0 || dl_wr !== 1'b1 || dl_addr !== 17'h1C100 || dl_data !== 8'h3C) begin
      errors++;
      $display("FAIL bram_pulse: wait=%0d dl_wr=%b addr=%h data=%h, required 0 1 1c100 3c",
               w, dl_wr, dl_addr, dl_data);
    end
    @(negedge clk_mem);
    checks++;
    if (dl_wr !== 1'b0) begin
      errors++;
      $display("FAIL bram_one_cycle: dl_wr=%b, required 0", dl_wr);
    end
    hps_write(25'h1D000, 8'h99, 8'h00, w);
    hps_write(25'h1C200, 8'h11, 8'h01, w);
    hps_write(25'h20005, 8'h22, 8'h00, w);
    repeat (3) @(negedge clk_mem);
    checks++;
    if (nb != 1 || n1 != 1 || n2 != 1 || dl_addr !== 17'h1C100 || port1_a !== 23'h1) begin
      errors++;
      $display("FAIL drop_silent: nb=%0d n1=%0d n2=%0d dla=%h, required 1 1 1 1c100",
               nb, n1, n2, dl_addr);
    end
  endtask

  task automatic test_timeout;
    int w;
    hold1 = 1;
    hps_write(25'h00100, 8'h77, 8'h00, w);
    checks++;
    if (w != 257) begin
      errors++;
      $display("FAIL timeout_len: ioctl_wait high %0d cycles, required 257", w);
    end
    checks++;
    if (dl_error !== 1'b1 || port1_req !== port1_ack) begin
      errors++;
      $display("FAIL timeout_flag: dl_error=%b req=%b ack=%b, required 1 and req==ack",
               dl_error, port1_req, port1_ack);
    end
    hold1 = 0;
    ioctl_download = 0;
    repeat (4) @(negedge clk_mem);
    checks++;
    if (rom_loaded !== 1'b0 || dl_error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_not_loaded: rom_loaded=%b dl_error=%b, required 0 1", rom_loaded, dl_error);
    end
  endtask

  task automatic test_full_download;
    logic [7:0] e1[int], e2[int], eb[int];
    int addrs[$];
    int x1 = 0, x2 = 0, xb = 0, s1, s2, sb, w;
    m1.delete();
    m2.delete();
    mb.delete();
    addrs = '{'h0, 'h1, 'h9FFF, 'hA000, 'hFFFF, 'h10000, 'h10001, 'h13FFF, 'h14000, 'h18000,
              'h1BFFF, 'h1C000, 'h1C31F, 'h1C320, 'h1FFFF, 'h20000, 'h1000000};
    for (int i = 0; i < 400; i++) addrs.push_back($urandom_range('h1C31F, 0));
    ioctl_download = 1;
    repeat (2) @(negedge clk_mem);
    checks++;
    if (dl_error !== 1'b0 || rom_loaded !== 1'b0) begin
      errors++;
      $display("FAIL dl_start_clear: dl_error=%b rom_loaded=%b, required 0 0", dl_error, rom_loaded);
    end
    lat_min = 0;
    lat_max = 5;
    s1 = n1;
    s2 = n2;
    sb = nb;
    foreach (addrs[i]) begin
      int ad, off, key;
      logic [7:0] d;
      ad = addrs[i];
      d = 8'($urandom);
      if (ad < 'h20000) begin
        if (ad <= 'h9FFF) begin
          e1[ad] = d;
          x1++;
        end else if (ad >= 'h10000 && ad <= 'h1BFFF) begin
          off = ad - 'h10000;
          key = (((off >> 16) << 15) | ((off & 'h3FFF) << 1) | ((off >> 15) & 1)) * 2 + ((off >> 14) & 1);
          e2[key] = d;
          x2++;
        end else if (ad <= 'h1C31F) begin
          eb[ad] = d;
          xb++;
        end
      end
      hps_write(25'(ad), d, 8'h00, w);
    end
    repeat (2) @(negedge clk_mem);
    checks++;
    if (n1 - s1 != x1 || n2 - s2 != x2 || nb - sb != xb) begin
      errors++;
      $display("FAIL dl_counts: p1=%0d p2=%0d bram=%0d, required %0d %0d %0d",
               n1 - s1, n2 - s2, nb - sb, x1, x2, xb);
    end
    foreach (e1[k]) begin
      checks++;
      if (!m1.exists(k) || m1[k] !== e1[k]) begin
        errors++;
        $display("FAIL dl_p1_byte %h: got %h, required %h", k, m1.exists(k) ? m1[k] : 8'hxx, e1[k]);
      end
    end
    foreach (e2[k]) begin
      checks++;
      if (!m2.exists(k) || m2[k] !== e2[k]) begin
        errors++;
        $display("FAIL dl_p2_byte key %h: got %h, required %h", k, m2.exists(k) ? m2[k] : 8'hxx, e2[k]);
      end
    end
    foreach (eb[k]) begin
      checks++;
      if (!mb.exists(k) || mb[k] !== eb[k]) begin
        errors++;
        $display("FAIL dl_bram_byte %h: got %h, required %h", k, mb.exists(k) ? mb[k] : 8'hxx, eb[k]);
      end
    end
    ioctl_download = 0;
    repeat (4) @(negedge clk_mem);
    checks++;
    if (rom_loaded !== 1'b1 || dl_error !== 1'b0) begin
      errors++;
      $display("FAIL dl_loaded: rom_loaded=%b dl_error=%b, required 1 0", rom_loaded, dl_error);
    end
  endtask

  task automatic test_reset_midwait;
    int w;
    ioctl_download = 1;
    repeat (2) @(negedge clk_mem);
    hold1 = 1;
    ioctl_addr = 25'h00200;
    ioctl_dout = 8'h5F;
    ioctl_index = 8'h00;
    ioctl_wr = 1;
    @(negedge clk_mem);
    ioctl_wr = 0;
    repeat (5) @(negedge clk_mem);
    checks++;
    if (ioctl_wait !== 1'b1 || port1_req === port1_ack) begin
      errors++;
      $display("FAIL midwait_busy: wait=%b req=%b ack=%b, required busy with req!=ack",
               ioctl_wait, port1_req, port1_ack);
    end
    reset = 1;
    @(negedge clk_mem);
    checks++;
    if (ioctl_wait !== 1'b0 || port1_req !== port1_ack || dl_error !== 1'b0) begin
      errors++;
      $display("FAIL midwait_reset: wait=%b req=%b ack=%b err=%b, required 0 req==ack 0",
               ioctl_wait, port1_req, port1_ack, dl_error);
    end
    reset = 0;
    hold1 = 0;
    lat_min = 0;
    lat_max = 0;
    repeat (2) @(negedge clk_mem);
    hps_write(25'h00201, 8'h42, 8'h00, w);
    checks++;
    if (w != 2 || port1_a !== 23'h100 || port1_ds !== 2'b10 || port1_d !== 16'h4242 || dl_error !== 1'b0) begin
      errors++;
      $display("FAIL midwait_recover: wait=%0d a=%h ds=%b d=%h err=%b, required 2 000100 10 4242 0",
               w, port1_a, port1_ds, port1_d, dl_error);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_p1_write();
    test_p2_write();
    test_bram_and_drop();
    test_timeout();
    test_full_download();
    test_reset_midwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
